// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Clock cycles per line bit.
    function automatic int unsigned bit_cyc(input int unsigned clock_rate,
                                            input int unsigned baud_rate);
        return clock_rate / baud_rate;
    endfunction

    // Reload value that spaces consecutive samples one full bit apart.
    function automatic int unsigned bit_dly(input int unsigned clock_rate,
                                            input int unsigned baud_rate);
        return bit_cyc(clock_rate, baud_rate) - 1;
    endfunction

    // Reload value that moves the first sample to the middle of the start bit.
    function automatic int unsigned half_dly(input int unsigned clock_rate,
                                             input int unsigned baud_rate);
        return bit_cyc(clock_rate, baud_rate) / 2 - 1;
    endfunction

    // Even-parity bit: XOR of all data bits.
    function automatic logic even_parity(input logic [BYTE_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rx line into the clk domain and flags falling edges.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic rx_m;
    logic rx_q;

    // Two-flop synchroniser plus an edge-history flop; all idle high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    // High for the one cycle in which the synchronised line has just dropped.
    assign fall = rx_q & ~rx_s;

endmodule

// File: rtl/uart_recv.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
module uart_recv
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [BYTE_W-1:0] data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int unsigned BIT_CYC = bit_cyc(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned DLY_W   = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam logic [DLY_W-1:0] BIT_DLY  = DLY_W'(bit_dly(CLOCK_RATE, BAUD_RATE));
    localparam logic [DLY_W-1:0] HALF_DLY = DLY_W'(half_dly(CLOCK_RATE, BAUD_RATE));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_W - 1);

    logic              rx_s;
    logic              fall;

    state_t            state,      state_nxt;
    logic [DLY_W-1:0]  delay,      delay_nxt;
    logic [IDX_W-1:0]  idx,        idx_nxt;
    logic [BYTE_W-1:0] shift,      shift_nxt;
    logic              par,        par_nxt;
    logic [BYTE_W-1:0] data_nxt;
    logic              valid_nxt;
    logic              parity_err_nxt;
    logic              frame_err_nxt;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            delay      <= '0;
            idx        <= '0;
            shift      <= '0;
            par        <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            delay      <= delay_nxt;
            idx        <= idx_nxt;
            shift      <= shift_nxt;
            par        <= par_nxt;
            data       <= data_nxt;
            valid      <= valid_nxt;
            parity_err <= parity_err_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    // Next-state and datapath: count down to each mid-bit sample, then act on it.
    always_comb begin
        state_nxt      = state;
        delay_nxt      = delay;
        idx_nxt        = idx;
        shift_nxt      = shift;
        par_nxt        = par;
        data_nxt       = data;
        valid_nxt      = 1'b0;
        parity_err_nxt = parity_err;
        frame_err_nxt  = frame_err;

        if (delay != '0) begin
            delay_nxt = delay - DLY_W'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (fall) begin
                        delay_nxt = HALF_DLY;
                        state_nxt = START;
                    end
                end
                START: begin
                    // A line already back high at mid-start was only a glitch.
                    if (!rx_s) begin
                        delay_nxt = BIT_DLY;
                        idx_nxt   = '0;
                        state_nxt = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                DATA: begin
                    shift_nxt = {rx_s, shift[BYTE_W-1:1]};
                    idx_nxt   = idx + IDX_W'(1);
                    delay_nxt = BIT_DLY;
                    if (idx == LAST_IDX) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    par_nxt   = rx_s;
                    delay_nxt = BIT_DLY;
                    state_nxt = STOP;
                end
                STOP: begin
                    // Returning to IDLE at mid-stop leaves time to catch a back-to-back start.
                    data_nxt       = shift;
                    parity_err_nxt = par ^ even_parity(shift);
                    frame_err_nxt  = ~rx_s;
                    valid_nxt      = 1'b1;
                    state_nxt      = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
